// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory.
//
// Handshake: a requester raises pN_req with pN_we/pN_addr/pN_wdata stable and
// keeps them stable until the arbiter answers with a single-cycle pN_done.
// The request fields are sampled only on the grant edge. pN_rdata is valid
// from pN_done and is held until the next read on that port completes. The
// requester drops pN_req while pN_done is high unless it wants another
// transaction. There is no back-pressure from the memory side: mem_read and
// mem_write are single-cycle strobes, and mem_rdata is valid the cycle after
// mem_read.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_done;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_done;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant;
  logic [1:0]        state_dbg;

  // Arbiter side.
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_done, p0_rdata, p1_done, p1_rdata,
    output mem_read, mem_write, mem_adr, mem_wdata,
    output busy, grant, state_dbg
  );

  // Requester / memory side.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_done, p0_rdata, p1_done, p1_rdata,
    input  mem_read, mem_write, mem_adr, mem_wdata,
    input  busy, grant, state_dbg
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared synchronous
// memory. Port 0 is instruction fetch, port 1 is data load/store. Every
// output comes straight from a flop.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // Port 1 wins when it is alone, or when both ask and port 0 went last.
  logic any_req;
  logic sel;
  logic we_sel;
  assign any_req = bus.p0_req | bus.p1_req;
  assign sel     = bus.p1_req & (~bus.p0_req | ~last_q);
  assign we_sel  = sel ? bus.p1_we : bus.p0_we;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: writes skip CAPTURE because nothing comes back from memory.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = write_q ? DONE : CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs for the current state.
  always_comb begin
    grant_d  = grant_q;
    last_d   = last_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    read_d   = read_q;
    write_d  = write_q;
    done0_d  = done0_q;
    done1_d  = done1_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_d = sel;
          last_d  = sel;
          adr_d   = sel ? bus.p1_addr : bus.p0_addr;
          wdata_d = sel ? bus.p1_wdata : bus.p0_wdata;
          read_d  = ~we_sel;
          write_d = we_sel;
        end else begin
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      ACCESS: begin
        // Memory samples the strobe at this edge; writes finish right here.
        read_d  = 1'b0;
        write_d = 1'b0;
        if (write_q) begin
          if (grant_q) done1_d = 1'b1;
          else         done0_d = 1'b1;
        end
      end
      CAPTURE: begin
        if (grant_q) begin
          rdata1_d = bus.mem_rdata;
          done1_d  = 1'b1;
        end else begin
          rdata0_d = bus.mem_rdata;
          done0_d  = 1'b1;
        end
      end
      DONE: begin
        done0_d = 1'b0;
        done1_d = 1'b0;
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears a pending strobe so an aborted write never lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      adr_q    <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      grant_q  <= grant_d;
      last_q   <= last_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.mem_read  = read_q;
  assign bus.mem_write = write_q;
  assign bus.mem_adr   = adr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.p0_done   = done0_q;
  assign bus.p1_done   = done1_q;
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state != IDLE);
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transactions, a synchronous memory model,
// and monitors that pop expected strobes and responses from queues.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct packed {
    logic          g;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous memory: strobes sampled on the rising edge, data out next cycle.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_adr] <= bus.mem_wdata;
    if (bus.mem_read)  bus.mem_rdata    <= mem[bus.mem_adr];
  end

  // ---------------- scoreboard state ----------------
  txn_t          exp_txn_q[$];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ref_rd0 = '0;
  logic [DW-1:0] ref_rd1 = '0;
  logic [DW-1:0] held0 = '0;
  logic [DW-1:0] held1 = '0;
  logic          prev_done0 = 1'b0;
  logic          prev_done1 = 1'b0;
  logic          prev_strobe = 1'b0;
  logic          chk_gap = 1'b0;
  logic          gap_armed = 1'b0;
  logic          last_we = 1'b0;
  int            last_strobe_cyc = 0;
  txn_t          e_txn;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // ---------------- monitors ----------------
  always @(posedge reset) begin
    held0       = '0;
    held1       = '0;
    prev_done0  = 1'b0;
    prev_done1  = 1'b0;
    prev_strobe = 1'b0;
  end

  // Memory-side monitor: every strobe must match the next expected transaction.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_read || bus.mem_write) begin
        check("strobe_exclusive", 32'(bus.mem_read & bus.mem_write), 32'(0));
        check("strobe_one_cycle", 32'(prev_strobe), 32'(0));
        if (exp_txn_q.size() == 0) begin
          n_checks++;
          $display("FAIL strobe_unexpected: got grant %0d adr 0x%0h, required no strobe",
                   bus.grant, bus.mem_adr);
        end else begin
          e_txn = exp_txn_q.pop_front();
          check("strobe_grant", 32'(bus.grant), 32'(e_txn.g));
          check("strobe_write", 32'(bus.mem_write), 32'(e_txn.we));
          check("strobe_adr", 32'(bus.mem_adr), 32'(e_txn.a));
          if (e_txn.we) check("strobe_wdata", 32'(bus.mem_wdata), 32'(e_txn.d));
        end
        if (chk_gap && gap_armed)
          check("strobe_gap", 32'(cyc - last_strobe_cyc), last_we ? 32'(3) : 32'(4));
        gap_armed       = 1'b1;
        last_strobe_cyc = cyc;
        last_we         = bus.mem_write;
      end
      prev_strobe = bus.mem_read | bus.mem_write;
    end
  end

  // Requester-side monitor: done pulses pop expected rdata; otherwise rdata holds.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.p0_done) begin
        check("p0_done_one_cycle", 32'(prev_done0), 32'(0));
        check("p0_done_grant", 32'(bus.grant), 32'(0));
        if (exp_q0.size() == 0) begin
          n_checks++;
          $display("FAIL p0_unexpected_done: got done=1, required done=0");
        end else begin
          held0 = exp_q0.pop_front();
          check("p0_rdata", 32'(bus.p0_rdata), 32'(held0));
        end
      end else begin
        check("p0_rdata_hold", 32'(bus.p0_rdata), 32'(held0));
      end
      if (bus.p1_done) begin
        check("p1_done_one_cycle", 32'(prev_done1), 32'(0));
        check("p1_done_grant", 32'(bus.grant), 32'(1));
        if (exp_q1.size() == 0) begin
          n_checks++;
          $display("FAIL p1_unexpected_done: got done=1, required done=0");
        end else begin
          held1 = exp_q1.pop_front();
          check("p1_rdata", 32'(bus.p1_rdata), 32'(held1));
        end
      end else begin
        check("p1_rdata_hold", 32'(bus.p1_rdata), 32'(held1));
      end
      prev_done0 = bus.p0_done;
      prev_done1 = bus.p1_done;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic done_of(input logic p);
    return p ? bus.p1_done : bus.p0_done;
  endfunction

  task automatic drive_port(input logic p, input logic r, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin
      bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    end else begin
      bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    end
  endtask

  task automatic expect_strobe(input logic p, input logic we,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_txn_q.push_back('{g: p, we: we, a: a, d: d});
  endtask

  task automatic expect_read(input logic p, input logic [AW-1:0] a);
    if (p) begin ref_rd1 = ref_mem[a]; exp_q1.push_back(ref_rd1); end
    else   begin ref_rd0 = ref_mem[a]; exp_q0.push_back(ref_rd0); end
  endtask

  task automatic expect_write(input logic p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ref_mem[a] = d;
    if (p) exp_q1.push_back(ref_rd1);
    else   exp_q0.push_back(ref_rd0);
  endtask

  // One isolated transaction with latency checks from strobe to done.
  task automatic txn(input logic p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen;
    int lat;
    expect_strobe(p, we, a, d);
    if (we) expect_write(p, a, d);
    else    expect_read(p, a);
    @(negedge clk);
    drive_port(p, 1'b1, we, a, d);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) begin seen = 1; break; end
    end
    check($sformatf("p%0d_strobe_seen", p), 32'(seen), 32'(1));
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (done_of(p)) break;
    end
    check($sformatf("p%0d_done_latency", p), 32'(lat), we ? 32'(1) : 32'(2));
    drive_port(p, 1'b0, 1'b0, a, d);
  endtask

  // Holds req high across n reads at base, base+1, ...
  task automatic run_port(input logic p, input int n, input logic [AW-1:0] base);
    bit seen;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      drive_port(p, 1'b1, 1'b0, AW'(base + i), '0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done_of(p)) begin seen = 1; break; end
      end
      check($sformatf("p%0d_run_done_seen", p), 32'(seen), 32'(1));
    end
    drive_port(p, 1'b0, 1'b0, base, '0);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_mem_read"},  32'(bus.mem_read),  32'(0));
    check({pfx, "_mem_write"}, 32'(bus.mem_write), 32'(0));
    check({pfx, "_mem_adr"},   32'(bus.mem_adr),   32'(0));
    check({pfx, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(0));
    check({pfx, "_p0_done"},   32'(bus.p0_done),   32'(0));
    check({pfx, "_p1_done"},   32'(bus.p1_done),   32'(0));
    check({pfx, "_p0_rdata"},  32'(bus.p0_rdata),  32'(0));
    check({pfx, "_p1_rdata"},  32'(bus.p1_rdata),  32'(0));
    check({pfx, "_busy"},      32'(bus.busy),      32'(0));
    check({pfx, "_grant"},     32'(bus.grant),     32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    ref_rd0   = '0;
    ref_rd1   = '0;
    gap_armed = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 256; i++) begin
      mem[i]     <= DW'(i) ^ 8'h5A;
      ref_mem[i]  = DW'(i) ^ 8'h5A;
    end
    mem[8'h10]     <= 8'hA5; ref_mem[8'h10] = 8'hA5;
    mem[8'h30]     <= 8'h77; ref_mem[8'h30] = 8'h77;

    // Power-up reset.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    reset = 1'b0;

    // p0 read of 0x10 returns 0xA5 and holds it.
    txn(1'b0, 1'b0, 8'h10, 8'h00);
    check("t2_p0_rdata", 32'(bus.p0_rdata), 32'(8'hA5));
    repeat (3) @(negedge clk);
    check("t2_p0_rdata_held", 32'(bus.p0_rdata), 32'(8'hA5));
    check("t2_idle_busy", 32'(bus.busy), 32'(0));

    // p1 write 0x3C to 0x20, then read it back.
    txn(1'b1, 1'b1, 8'h20, 8'h3C);
    check("t3_p1_rdata_after_write", 32'(bus.p1_rdata), 32'(8'h00));
    txn(1'b1, 1'b0, 8'h20, 8'h00);
    check("t3_p1_rdata", 32'(bus.p1_rdata), 32'(8'h3C));
    check("t3_p0_rdata", 32'(bus.p0_rdata), 32'(8'hA5));
    check("t3_mem", 32'(mem[8'h20]), 32'(8'h3C));

    // Simultaneous reads right after reset: p0 first, then p1.
    do_reset();
    expect_strobe(1'b0, 1'b0, 8'h40, 8'h00);
    expect_strobe(1'b1, 1'b0, 8'h50, 8'h00);
    expect_read(1'b0, 8'h40);
    expect_read(1'b1, 8'h50);
    chk_gap = 1'b1;
    fork
      run_port(1'b0, 1, 8'h40);
      run_port(1'b1, 1, 8'h50);
    join
    chk_gap = 1'b0;
    check("t4_p0_rdata", 32'(bus.p0_rdata), 32'(8'h40 ^ 8'h5A));
    check("t4_p1_rdata", 32'(bus.p1_rdata), 32'(8'h50 ^ 8'h5A));

    // Continuous contention: grants alternate 0,1,0,1,0,1.
    for (int i = 0; i < 3; i++) begin
      expect_strobe(1'b0, 1'b0, AW'(8'h60 + i), 8'h00);
      expect_strobe(1'b1, 1'b0, AW'(8'h70 + i), 8'h00);
      expect_read(1'b0, AW'(8'h60 + i));
      expect_read(1'b1, AW'(8'h70 + i));
    end
    gap_armed = 1'b0;
    chk_gap   = 1'b1;
    fork
      run_port(1'b0, 3, 8'h60);
      run_port(1'b1, 3, 8'h70);
    join
    chk_gap = 1'b0;
    check("t5_strobes_consumed", 32'(exp_txn_q.size()), 32'(0));
    check("t5_p1_rdata", 32'(bus.p1_rdata), 32'(8'h72 ^ 8'h5A));

    // Reset in the middle of a p0 read: everything back to reset values, no done.
    @(negedge clk);
    expect_strobe(1'b0, 1'b0, 8'h11, 8'h00);
    drive_port(1'b0, 1'b1, 1'b0, 8'h11, 8'h00);
    @(negedge clk);
    #2;
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    ref_rd0 = '0;
    ref_rd1 = '0;
    #1;
    check_reset("t1");
    repeat (2) @(negedge clk);
    check_reset("t1_hold");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("t1_busy_after", 32'(bus.busy), 32'(0));
    check("t1_grant_after", 32'(bus.grant), 32'(0));

    // Reset pulse during ACCESS of a p1 write: the write must not land.
    @(negedge clk);
    drive_port(1'b1, 1'b1, 1'b1, 8'h30, 8'hFF);
    @(posedge clk);
    #2;
    check("t6_write_strobe_up", 32'(bus.mem_write), 32'(1));
    check("t6_busy_up", 32'(bus.busy), 32'(1));
    reset = 1'b1;
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    ref_rd0 = '0;
    ref_rd1 = '0;
    #1;
    check("t6_write_strobe_cleared", 32'(bus.mem_write), 32'(0));
    check("t6_grant_reset", 32'(bus.grant), 32'(0));
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_mem_untouched", 32'(mem[8'h30]), 32'(8'h77));
    txn(1'b1, 1'b0, 8'h30, 8'h00);
    check("t6_p1_readback", 32'(bus.p1_rdata), 32'(8'h77));

    repeat (5) @(negedge clk);
    check("end_strobe_q_empty", 32'(exp_txn_q.size()), 32'(0));
    check("end_p0_q_empty", 32'(exp_q0.size()), 32'(0));
    check("end_p1_q_empty", 32'(exp_q1.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the shared 8-bit synchronous external memory.
- Port 0 is instruction fetch; port 1 is data load/store.
- Serialises requests, drives the memory's memread/memwrite/adr/writedata, captures memdata one cycle after the read strobe, and returns data with a one-cycle done pulse to the granted requester.

Parameters:
ADDR_W, 8, address width (memory depth 2^ADDR_W)
DATA_W, 8, data width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
p0_req  input  1  port 0 request; hold stable until p0_done
p0_we  input  1  port 0 direction: 1 write, 0 read
p0_addr  input  ADDR_W  port 0 address
p0_wdata  input  DATA_W  port 0 write data
p0_done  output  1  one-cycle completion pulse
p0_rdata  output  DATA_W  port 0 read data, valid from p0_done, held until next port 0 read completes
p1_req, p1_we, p1_addr, p1_wdata, p1_done, p1_rdata  same as port 0, for port 1
mem_read  output  1  to memory memread
mem_write  output  1  to memory memwrite
mem_adr  output  ADDR_W  to memory adr
mem_wdata  output  DATA_W  to memory writedata
mem_rdata  input  DATA_W  from memory memdata
busy  output  1  high in any state other than IDLE
grant  output  1  port owning the current transaction (0/1); holds last value in IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; mem_read=mem_write=0; mem_adr=0; mem_wdata=0; p0_done=p1_done=0; p0_rdata=p1_rdata=0; grant=0; last_grant=1, so port 0 wins the first contention.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE: req sampled at the rising edge.
  - One requester: that port wins.
  - Both requesting: the port != last_grant wins.
  - On win (edge N): latch grant, last_grant<=grant, mem_adr<=addr, mem_wdata<=wdata, mem_read<=~we, mem_write<=we; go to ACCESS.
  - No request: stay in IDLE with strobes low.
- ACCESS (edge N+1): memory samples its strobe at this edge.
  - Clear both strobes.
  - Read goes to CAPTURE.
  - Write goes to DONE and asserts the granted port's done.
- CAPTURE (edge N+2): granted port's rdata<=mem_rdata; assert its done; go to DONE.
- DONE (next edge): done<=0; go to IDLE.
- Latency, request sampled at edge N:
  - Write: memory updated at N+1, done high N+1..N+2.
  - Read: done and rdata valid N+2..N+3.
- Throughput: back-to-back transactions are 3 cycles apart (write) and 4 cycles apart (read).
- Requester rules:
  - Must drop req in the cycle its done is high unless it wants another transaction.
  - req is not sampled in ACCESS, CAPTURE or DONE.
  - addr/we/wdata are sampled only at the grant edge; later changes have no effect.
- At most one of mem_read/mem_write is high, for exactly one cycle per transaction; both are low in IDLE, CAPTURE and DONE.
- A write never changes either rdata.
- The non-granted port's done and rdata are unaffected by the other port's transaction.
- Address range is the full 0..2^ADDR_W-1; no wrap or bounds logic.
- Reset mid-transaction: everything returns to reset values at once.
  - No done is issued for the aborted transaction.
  - An aborted write whose strobe is not yet sampled must not reach memory.
- A request arriving the same cycle reset deasserts is sampled at the first rising edge with reset low.

Test Plan:
1. Reset asserted mid-run, with memory preloaded and p0 reading -> all outputs at reset values immediately; busy=0; no p0_done; grant=0.
2. p0 read addr 0x10 (mem=0xA5) requested at edge N -> mem_read high exactly N..N+1 with mem_adr=0x10; p0_done high N+2..N+3; p0_rdata=0xA5 and held; p1_done stays 0.
3. p1 write 0x3C to addr 0x20, then p1 read 0x20 -> mem_write one cycle with mem_wdata=0x3C; p1_done 1 cycle after the write strobe; readback p1_rdata=0x3C; p0_rdata unchanged.
4. p0 and p1 both request reads at the same edge after reset -> p0 served first, then p1 with no idle gap beyond the DONE/IDLE cycles; both rdata values correct; grant sequence 0,1.
5. p0 and p1 hold req continuously for 6 transactions -> grants strictly alternate 0,1,0,1,0,1; never two consecutive grants to one port while the other waits.
6. Reset pulsed during ACCESS of a p1 write of 0xFF to 0x30 (pulse before strobe sampled) -> mem[0x30] unchanged; no p1_done; a subsequent p1 read of 0x30 returns the original value.
